hash_lookup: RTL and testbench



---
 rtl/hash_lookup_if.sv | 46 ++++
 rtl/hash_lookup.sv | 212 +++++++++++++++++++++
 tb/tb_hash_lookup.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/hash_lookup_if.sv
// ---------------------------------------------------------------------------
// hash_lookup_if
//   Bundles the lookup stream, the table write port and the output stream of
//   hash_lookup.
//
//   Lookup side : in_hash, in_tag, in_v (from hash pipeline), ce_out (stall back)
//   Table write : tbl_wr_en, tbl_wr_addr, tbl_wr_rule, tbl_wr_vld
//   Output side : m_valid, m_rule, m_tag (to consumer), m_ready (from consumer)
//
//   modport slave  : the hash_lookup block itself
//   modport master : whoever drives lookups/writes and consumes results
// ---------------------------------------------------------------------------
interface hash_lookup_if #(
    parameter int NBITS  = 15,
    parameter int TAG_W  = 16,
    parameter int RULE_W = 16
);
    logic [NBITS-1:0]  in_hash;
    logic [TAG_W-1:0]  in_tag;
    logic              in_v;
    logic              ce_out;

    logic              tbl_wr_en;
    logic [NBITS-1:0]  tbl_wr_addr;
    logic [RULE_W-1:0] tbl_wr_rule;
    logic              tbl_wr_vld;

    logic              m_valid;
    logic              m_ready;
    logic [RULE_W-1:0] m_rule;
    logic [TAG_W-1:0]  m_tag;

    modport slave (
        input  in_hash, in_tag, in_v,
        input  tbl_wr_en, tbl_wr_addr, tbl_wr_rule, tbl_wr_vld,
        input  m_ready,
        output ce_out, m_valid, m_rule, m_tag
    );

    modport master (
        output in_hash, in_tag, in_v,
        output tbl_wr_en, tbl_wr_addr, tbl_wr_rule, tbl_wr_vld,
        output m_ready,
        input  ce_out, m_valid, m_rule, m_tag
    );
endinterface

// File: rtl/hash_lookup.sv
// ---------------------------------------------------------------------------
// hash_lookup
//   Rule-table lookup stage behind the multiplicative hash unit. Each accepted
//   hash index reads a 2^NBITS-entry table of {vld, rule}; hits are queued as
//   {rule, tag} in a small show-ahead FIFO, misses are dropped. The block
//   back-pressures the hash pipeline through ce_out using a credit rule so
//   the FIFO can never overflow. After reset the table is cleared by an
//   internal sweep of one address per cycle.
//
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     bus        : hash_lookup_if.slave (lookup in, table write, result out)
//     init_done  : high once the clear sweep has finished
//     hit_cnt    : wrapping count of lookups that hit
//     miss_cnt   : wrapping count of lookups that missed
// ---------------------------------------------------------------------------
module hash_lookup #(
    parameter int NBITS      = 15,
    parameter int TAG_W      = 16,
    parameter int RULE_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    hash_lookup_if.slave bus,
    output logic        init_done,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int ENTRY_W = RULE_W + TAG_W;
    localparam logic [NBITS-1:0] LAST_ADDR = '1;

    // -----------------------------------------------------------------------
    // Control FSM: INIT sweeps the table, RUN serves traffic
    // -----------------------------------------------------------------------
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [NBITS-1:0]  sweep_addr_reg, sweep_addr_next;
    logic              ram_we;
    logic [NBITS-1:0]  ram_waddr;
    logic [RULE_W:0]   ram_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= INIT;
            sweep_addr_reg <= '0;
        end else begin
            state_reg      <= state_next;
            sweep_addr_reg <= sweep_addr_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        sweep_addr_next = sweep_addr_reg;
        ram_we          = 1'b0;
        ram_waddr       = bus.tbl_wr_addr;
        ram_wdata       = {bus.tbl_wr_vld, bus.tbl_wr_rule};
        case (state_reg)
            INIT: begin
                // External writes are ignored while the sweep owns the port.
                ram_we          = 1'b1;
                ram_waddr       = sweep_addr_reg;
                ram_wdata       = '0;
                sweep_addr_next = sweep_addr_reg + NBITS'(1);
                if (sweep_addr_reg == LAST_ADDR) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                ram_we = bus.tbl_wr_en;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    assign init_done = (state_reg == RUN);

    // -----------------------------------------------------------------------
    // Rule table: one write port, one registered read port (read-first, so a
    // same-cycle write to the looked-up address returns the old entry)
    // -----------------------------------------------------------------------
    logic [RULE_W:0] tbl_mem [2**NBITS];
    logic [RULE_W:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            tbl_mem[ram_waddr] <= ram_wdata;
        end
        rd_data_reg <= tbl_mem[bus.in_hash];
    end

    // -----------------------------------------------------------------------
    // Lookup pipeline
    // -----------------------------------------------------------------------
    logic              ce;
    logic              accept;
    logic              s1_v_reg, s2_v_reg;
    logic [TAG_W-1:0]  s1_tag_reg, s2_tag_reg;
    logic [RULE_W:0]   s2_entry_reg;
    logic              hit, miss;

    assign accept = bus.in_v & ce;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_reg <= 1'b0;
            s2_v_reg <= 1'b0;
        end else begin
            s1_v_reg <= accept;
            s2_v_reg <= s1_v_reg;
        end
    end

    // Payload registers need no reset; they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        s1_tag_reg   <= bus.in_tag;
        s2_tag_reg   <= s1_tag_reg;
        s2_entry_reg <= rd_data_reg;
    end

    assign hit  = s2_v_reg &  s2_entry_reg[RULE_W];
    assign miss = s2_v_reg & ~s2_entry_reg[RULE_W];

    logic [31:0] hit_cnt_reg, miss_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else begin
            if (hit) begin
                hit_cnt_reg <= hit_cnt_reg + 32'd1;
            end
            if (miss) begin
                miss_cnt_reg <= miss_cnt_reg + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_reg;
    assign miss_cnt = miss_cnt_reg;

    // -----------------------------------------------------------------------
    // Output FIFO (show-ahead)
    // -----------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [OCC_W-1:0]   occ_reg;
    logic               push, pop;
    logic               m_valid_int;
    logic [ENTRY_W-1:0] fifo_head;

    assign push        = hit;
    assign m_valid_int = (occ_reg != '0);
    assign pop         = m_valid_int & bus.m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            // Depth is a power of two, so pointers wrap naturally.
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ_reg <= occ_reg + OCC_W'(1);
                2'b01:   occ_reg <= occ_reg - OCC_W'(1);
                default: occ_reg <= occ_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {s2_entry_reg[RULE_W-1:0], s2_tag_reg};
        end
    end

    assign fifo_head   = fifo_mem[rd_ptr_reg];
    assign bus.m_valid = m_valid_int;
    // Gate the data so the outputs read 0 whenever nothing is presented.
    assign bus.m_rule  = m_valid_int ? fifo_head[ENTRY_W-1:TAG_W] : '0;
    assign bus.m_tag   = m_valid_int ? fifo_head[TAG_W-1:0]       : '0;

    // -----------------------------------------------------------------------
    // Credit-based stall: every lookup in the pipeline holds a FIFO slot, so
    // accepting only while occ + inflight < depth guarantees room for it.
    // -----------------------------------------------------------------------
    logic [OCC_W:0] credit_sum;

    assign credit_sum = {1'b0, occ_reg} + (OCC_W+1)'(s1_v_reg) + (OCC_W+1)'(s2_v_reg);
    assign ce         = (state_reg == RUN) && (credit_sum < (OCC_W+1)'(FIFO_DEPTH));
    assign bus.ce_out = ce;

    assert property (@(posedge clk) disable iff (rst)
        !(push && (occ_reg == OCC_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_hash_lookup.sv
// ---------------------------------------------------------------------------
// tb_hash_lookup
//   Directed bench for hash_lookup: init sweep timing, hit/miss behaviour,
//   read-first collision, FIFO fill/drain under back-pressure and mid-run
//   reset. Expected values are hand-derived constants.
// ---------------------------------------------------------------------------
module tb_hash_lookup;
    localparam int NB    = 15;
    localparam int TW    = 16;
    localparam int RW    = 16;
    localparam int DEPTH = 8;
    localparam int TBL_N = 2**NB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int errors = 0;
    int checks = 0;

    hash_lookup_if #(.NBITS(NB), .TAG_W(TW), .RULE_W(RW)) bus ();

    hash_lookup #(
        .NBITS(NB), .TAG_W(TW), .RULE_W(RW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .init_done (init_done),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tbl_write(input logic [NB-1:0] a, input logic [RW-1:0] r, input logic v);
        bus.tbl_wr_en   = 1'b1;
        bus.tbl_wr_addr = a;
        bus.tbl_wr_rule = r;
        bus.tbl_wr_vld  = v;
        tick();
        bus.tbl_wr_en   = 1'b0;
        $display("write addr=0x%0h rule=0x%0h vld=%0d", a, r, v);
    endtask

    task automatic lookup(input logic [NB-1:0] h, input logic [TW-1:0] t);
        check("ce_before_lookup", bus.ce_out, 1);
        bus.in_v    = 1'b1;
        bus.in_hash = h;
        bus.in_tag  = t;
        tick();
        bus.in_v    = 1'b0;
        $display("lookup hash=0x%0h tag=0x%0h", h, t);
    endtask

    // Runs the sweep window after rst deasserts; all outputs must stay quiet.
    task automatic wait_sweep(input string tag);
        int bad;
        bad = 0;
        for (int i = 1; i < TBL_N; i++) begin
            tick();
            if (bus.m_valid || bus.ce_out || init_done || hit_cnt != 0 ||
                miss_cnt != 0 || bus.m_rule != 0 || bus.m_tag != 0) bad++;
        end
        check({tag, "_quiet"}, bad, 0);
        check({tag, "_done_early"}, init_done, 0);
        tick();
        check({tag, "_done"}, init_done, 1);
        check({tag, "_ce_up"}, bus.ce_out, 1);
        $display("init sweep %s finished", tag);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int idx;
        logic acc_now;

        bus.in_v = 0; bus.in_hash = '0; bus.in_tag = '0;
        bus.tbl_wr_en = 0; bus.tbl_wr_addr = '0; bus.tbl_wr_rule = '0; bus.tbl_wr_vld = 0;
        bus.m_ready = 0;

        // Reset and first sweep
        rst = 1'b1;
        tick();
        tick();
        check("rst_ce", bus.ce_out, 0);
        check("rst_mvalid", bus.m_valid, 0);
        check("rst_init_done", init_done, 0);
        check("rst_hits", hit_cnt, 0);
        check("rst_misses", miss_cnt, 0);
        rst = 1'b0;
        wait_sweep("init1");

        // Basic hit with latency 2
        tbl_write(15'h1234, 16'h00AB, 1'b1);
        lookup(15'h1234, 16'h0055);
        check("hit_lat0", bus.m_valid, 0);
        tick();
        check("hit_lat1", bus.m_valid, 0);
        tick();
        check("hit_valid", bus.m_valid, 1);
        check("hit_rule", bus.m_rule, 16'h00AB);
        check("hit_tag", bus.m_tag, 16'h0055);
        check("hit_cnt1", hit_cnt, 1);
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        check("hit_popped", bus.m_valid, 0);

        // Miss on unwritten address, then on a deleted entry
        lookup(15'h0007, 16'h0001);
        tick(); tick();
        check("miss_unwritten_valid", bus.m_valid, 0);
        check("miss_cnt1", miss_cnt, 1);
        tbl_write(15'h1234, 16'h00AB, 1'b0);
        lookup(15'h1234, 16'h0002);
        tick(); tick();
        check("miss_deleted_valid", bus.m_valid, 0);
        check("miss_cnt2", miss_cnt, 2);
        check("hit_cnt_still1", hit_cnt, 1);

        // Same-cycle write and lookup: old data, next lookup sees new data
        bus.tbl_wr_en = 1'b1; bus.tbl_wr_addr = 15'h0100;
        bus.tbl_wr_rule = 16'h0011; bus.tbl_wr_vld = 1'b1;
        bus.in_v = 1'b1; bus.in_hash = 15'h0100; bus.in_tag = 16'h00A1;
        tick();
        bus.tbl_wr_en = 1'b0;
        bus.in_tag = 16'h00A2;
        tick();
        bus.in_v = 1'b0;
        $display("collision write+lookup 0x100 then lookup 0x100");
        tick();
        check("coll_first_valid", bus.m_valid, 0);
        check("coll_miss_cnt3", miss_cnt, 3);
        tick();
        check("coll_second_valid", bus.m_valid, 1);
        check("coll_second_rule", bus.m_rule, 16'h0011);
        check("coll_second_tag", bus.m_tag, 16'h00A2);
        check("coll_hit_cnt2", hit_cnt, 2);
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        check("coll_popped", bus.m_valid, 0);

        // Fill the FIFO under back-pressure
        for (int i = 0; i < 9; i++) begin
            tbl_write(NB'(15'h0200 + i), RW'(16'h0100 + i), 1'b1);
        end
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            bus.in_v    = 1'b1;
            bus.in_hash = NB'(15'h0200 + idx);
            bus.in_tag  = TW'(16'h0300 + idx);
            acc_now     = bus.ce_out;
            tick();
            if (acc_now) idx++;
        end
        bus.in_v = 1'b0;
        $display("fill: %0d lookups accepted with m_ready low", idx);
        check("fill_accepted", idx, DEPTH);
        check("fill_ce_low", bus.ce_out, 0);
        check("fill_valid", bus.m_valid, 1);
        check("fill_hit_cnt", hit_cnt, 10);

        // Drain in order
        bus.m_ready = 1'b1;
        for (int j = 0; j < DEPTH; j++) begin
            check("drain_valid", bus.m_valid, 1);
            check("drain_rule", bus.m_rule, 64'h0100 + j);
            check("drain_tag", bus.m_tag, 64'h0300 + j);
            $display("drain entry %0d rule=0x%0h tag=0x%0h", j, bus.m_rule, bus.m_tag);
            tick();
            if (j == 0) check("drain_ce_back", bus.ce_out, 1);
        end
        bus.m_ready = 1'b0;
        check("drain_empty", bus.m_valid, 0);
        check("drain_hit_cnt", hit_cnt, 10);

        // Reset with 3 queued and 2 in flight
        for (int i = 0; i < 5; i++) begin
            bus.in_v    = 1'b1;
            bus.in_hash = NB'(15'h0200 + i);
            bus.in_tag  = TW'(16'h0400 + i);
            tick();
        end
        bus.in_v = 1'b0;
        check("pre_rst_valid", bus.m_valid, 1);
        check("pre_rst_hit_cnt", hit_cnt, 13);
        rst = 1'b1;
        tick();
        $display("mid-run reset asserted");
        check("mrst_valid", bus.m_valid, 0);
        check("mrst_hits", hit_cnt, 0);
        check("mrst_misses", miss_cnt, 0);
        check("mrst_init_done", init_done, 0);
        check("mrst_ce", bus.ce_out, 0);
        rst = 1'b0;
        wait_sweep("init2");

        // Table contents lost
        lookup(15'h0200, 16'h0500);
        tick(); tick();
        check("post_rst_valid", bus.m_valid, 0);
        check("post_rst_miss", miss_cnt, 1);
        check("post_rst_hit", hit_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
